// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encodings and lamp codes for the intersection controllers
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_HG = 2'd0,
        PH_HY = 2'd1,
        PH_CG = 2'd2,
        PH_CY = 2'd3
    } phase_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_HG:   return PH_HY;
            PH_HY:   return PH_CG;
            PH_CG:   return PH_CY;
            default: return PH_HG;
        endcase
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - two-flop synchronizer followed by a consecutive-sample debounce counter
module sensor_debounce #(
    parameter int DB_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic db_o
);

    localparam int CW = $clog2(DB_LEN + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DB_LEN);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Once DB_LEN differing samples are counted, the flip lands on the following edge.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (cnt_q == CNT_FULL) begin
            db_d = ~db_q;
        end else if (sync2_q != db_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_o = db_q;

endmodule

// File: rtl/cr_phase_timer.sv
// rtl/cr_phase_timer.sv - phase timer and sensor request latch feeding the country-road controller
module cr_phase_timer
    import traffic_pkg::*;
#(
    parameter int CLK_DIV = 1000,
    parameter int T_HG    = 30,
    parameter int T_HY    = 3,
    parameter int T_CG    = 10,
    parameter int T_CY    = 3,
    parameter int DB_LEN  = 4,
    parameter int TW      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_raw,
    output logic       sensor_req,
    output logic       time_out,
    output logic [1:0] phase
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_DIV - 1);

    phase_e        phase_q, phase_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d, tcnt_last;
    logic          done_q, done_d;
    logic          time_out_q, time_out_d;
    logic          req_q, req_d;
    logic          db, tick, expired, advance;

    sensor_debounce #(
        .DB_LEN(DB_LEN)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_i (sensor_raw),
        .db_o  (db)
    );

    always_comb begin
        tcnt_last = TW'(T_HG - 1);
        case (phase_q)
            PH_HY:   tcnt_last = TW'(T_HY - 1);
            PH_CG:   tcnt_last = TW'(T_CG - 1);
            PH_CY:   tcnt_last = TW'(T_CY - 1);
            default: tcnt_last = TW'(T_HG - 1);
        endcase
    end

    assign tick    = (pcnt_q == PCNT_LAST);
    assign expired = tick && (tcnt_q == tcnt_last);

    always_comb begin
        advance = 1'b0;
        done_d  = done_q;
        pcnt_d  = tick ? '0 : pcnt_q + 1'b1;
        tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;
        req_d   = req_q;
        if (phase_q == PH_HG) begin
            // HG only leaves once its minimum has elapsed and a request is latched.
            if ((done_q || expired) && req_q) begin
                advance = 1'b1;
            end else if (done_q) begin
                pcnt_d = pcnt_q;
                tcnt_d = tcnt_q;
            end else if (expired) begin
                done_d = 1'b1;
                pcnt_d = '0;
                tcnt_d = tcnt_q;
            end
        end else begin
            advance = expired;
        end

        phase_d    = phase_q;
        time_out_d = advance;
        if (advance) begin
            phase_d = next_phase(phase_q);
            pcnt_d  = '0;
            tcnt_d  = '0;
            done_d  = 1'b0;
        end

        // Request is held through HY and dropped as CG begins; the clear has priority.
        req_d = (req_q || (db && (phase_q == PH_HG))) && !(advance && (phase_q == PH_HY));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= PH_HG;
            pcnt_q     <= '0;
            tcnt_q     <= '0;
            done_q     <= 1'b0;
            time_out_q <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            pcnt_q     <= pcnt_d;
            tcnt_q     <= tcnt_d;
            done_q     <= done_d;
            time_out_q <= time_out_d;
            req_q      <= req_d;
        end
    end

    assign phase      = phase_q;
    assign time_out   = time_out_q;
    assign sensor_req = req_q;

endmodule

// File: tb/tb_cr_phase_timer.sv
// tb/tb_cr_phase_timer.sv - scoreboard bench for cr_phase_timer against a cycle-level reference model
module tb_cr_phase_timer;

    localparam int CLK_DIV = 4;
    localparam int T_HG    = 3;
    localparam int T_HY    = 2;
    localparam int T_CG    = 3;
    localparam int T_CY    = 1;
    localparam int DB_LEN  = 4;
    localparam int TW      = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor_raw = 1'b0;
    logic       sensor_req;
    logic       time_out;
    logic [1:0] phase;

    cr_phase_timer #(
        .CLK_DIV(CLK_DIV), .T_HG(T_HG), .T_HY(T_HY), .T_CG(T_CG),
        .T_CY(T_CY), .DB_LEN(DB_LEN), .TW(TW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_raw (sensor_raw),
        .sensor_req (sensor_req),
        .time_out   (time_out),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    ev_t to_q[$];
    ev_t req_q[$];
    int  pulse_log[$];
    int  req_rise_log[$];
    bit  hist[int];

    // Reference model state: phase, edges since phase entry, request and debounced sensor.
    int  m_phase = 0;
    int  m_el    = 0;
    bit  m_req   = 1'b0;
    bit  m_db    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int dur(input int p);
        case (p)
            0:       return T_HG;
            1:       return T_HY;
            2:       return T_CG;
            default: return T_CY;
        endcase
    endfunction

    function automatic bit hist_at(input int k);
        if (k < 1 || !hist.exists(k)) return 1'b0;
        return hist[k];
    endfunction

    function automatic int log_at(input int q[$], input int i);
        if (i >= q.size()) return -1;
        return q[i];
    endfunction

    task automatic model_step(input bit r);
        bit all_v;
        bit adv;
        bit nreq;
        bit ndb;
        int nph;
        hist[cyc] = r;
        // A raw run sampled from edge s flips the debounced value at edge s+DB_LEN+2.
        ndb = m_db;
        if (cyc - DB_LEN - 2 >= 1) begin
            all_v = 1'b1;
            for (int k = cyc - DB_LEN - 2; k <= cyc - 3; k++)
                if (hist_at(k) == m_db) all_v = 1'b0;
            if (all_v) ndb = !m_db;
        end
        m_el++;
        if (m_phase == 0) adv = (m_el >= dur(0) * CLK_DIV) && m_req;
        else              adv = (m_el == dur(m_phase) * CLK_DIV);
        nph  = adv ? (m_phase + 1) % 4 : m_phase;
        nreq = (m_req || (m_db && m_phase == 0)) && !(adv && m_phase == 1);
        if (adv) begin
            to_q.push_back('{cyc, nph});
            m_el = 0;
        end
        if (nreq != m_req) req_q.push_back('{cyc, int'(nreq)});
        m_phase = nph;
        m_req   = nreq;
        m_db    = ndb;
    endtask

    // Called at posedge+1; r is the raw value sampled at the next edge.
    task automatic cycle1(input bit r);
        sensor_raw = r;
        @(posedge clk);
        cyc++;
        model_step(r);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1;
        chk("pending_events", to_q.size() + req_q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk("reset_time_out", int'(time_out), 0);
        chk("reset_sensor_req", int'(sensor_req), 0);
        chk("reset_phase", int'(phase), 0);
        to_q.delete();
        req_q.delete();
        pulse_log.delete();
        req_rise_log.delete();
        hist.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        cyc     = 0;
        m_phase = 0;
        m_el    = 0;
        m_req   = 1'b0;
        m_db    = 1'b0;
    endtask

    int  prev_phase = 0;
    bit  prev_req   = 1'b0;
    ev_t mon_ev;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_phase = 0;
            prev_req   = 1'b0;
        end else begin
            while (to_q.size() > 0 && to_q[0].cyc < cyc) begin
                mon_ev = to_q.pop_front();
                chk("missed_time_out", cyc, mon_ev.cyc);
            end
            while (req_q.size() > 0 && req_q[0].cyc < cyc) begin
                mon_ev = req_q.pop_front();
                chk("missed_req_change", cyc, mon_ev.cyc);
            end
            if (time_out) begin
                pulse_log.push_back(cyc);
                if (to_q.size() == 0) begin
                    chk("unexpected_time_out", 1, 0);
                end else begin
                    mon_ev = to_q.pop_front();
                    chk("time_out_cycle", cyc, mon_ev.cyc);
                    chk("phase_after_time_out", int'(phase), mon_ev.val);
                end
            end else begin
                chk("phase_stable_without_time_out", int'(phase), prev_phase);
            end
            if (sensor_req != prev_req) begin
                if (sensor_req) req_rise_log.push_back(cyc);
                if (req_q.size() == 0) begin
                    chk("unexpected_req_change", int'(sensor_req), int'(prev_req));
                end else begin
                    mon_ev = req_q.pop_front();
                    chk("req_change_cycle", cyc, mon_ev.cyc);
                    chk("req_value", int'(sensor_req), mon_ev.val);
                end
            end
            prev_phase = int'(phase);
            prev_req   = sensor_req;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit val;
        #2;
        chk("por_time_out", int'(time_out), 0);
        chk("por_sensor_req", int'(sensor_req), 0);
        chk("por_phase", int'(phase), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sensor held high from reset: full cycle repeating every 36 cycles.
        repeat (80) cycle1(1'b1);
        chk("t1_pulse0", log_at(pulse_log, 0), 12);
        chk("t1_pulse1", log_at(pulse_log, 1), 20);
        chk("t1_pulse2", log_at(pulse_log, 2), 32);
        chk("t1_pulse3", log_at(pulse_log, 3), 36);
        chk("t1_pulse4", log_at(pulse_log, 4), 48);

        // Sensor dropped during HY: request held, cleared at CG entry, CG is 12 cycles.
        apply_reset();
        while (m_phase != 1 && cyc < 100) cycle1(1'b1);
        repeat (60) cycle1(1'b0);
        chk("t4_pulse_count", pulse_log.size(), 4);
        chk("t4_cg_length", log_at(pulse_log, 2) - log_at(pulse_log, 1), 12);
        chk("t4_req_after", int'(sensor_req), 0);

        // Short glitches during HG never become a request.
        apply_reset();
        repeat (25) begin
            repeat (3) cycle1(1'b1);
            repeat (5) cycle1(1'b0);
        end
        chk("t3_req", int'(sensor_req), 0);
        chk("t3_phase", int'(phase), 0);
        chk("t3_pulses", pulse_log.size(), 0);

        // No request: HG indefinitely.
        apply_reset();
        repeat (1000) cycle1(1'b0);
        chk("t2_idle_pulses", pulse_log.size(), 0);
        chk("t2_idle_phase", int'(phase), 0);

        // Request arriving late in HG: sampled from cycle 100.
        apply_reset();
        while (cyc < 99) cycle1(1'b0);
        repeat (40) cycle1(1'b1);
        chk("t2_req_rise", log_at(req_rise_log, 0), 107);
        chk("t2_time_out", log_at(pulse_log, 0), 108);

        // Reset in the middle of CG discards progress.
        apply_reset();
        while (!(m_phase == 2 && m_el == 5) && cyc < 200) cycle1(1'b1);
        chk("t5_pre_reset_phase", int'(phase), 2);
        apply_reset();
        repeat (30) cycle1(1'b1);
        chk("t5_first_time_out", log_at(pulse_log, 0), 12);

        // Random run lengths kept clear of the debounce threshold region.
        apply_reset();
        val = 1'b0;
        while (cyc < 3000) begin
            val = !val;
            if ($urandom_range(0, 2) == 0) len = $urandom_range(1, DB_LEN - 1);
            else                           len = $urandom_range(DB_LEN + 3, 60);
            repeat (len) cycle1(val);
        end

        @(negedge clk);
        #1;
        chk("final_pending_events", to_q.size() + req_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cr_phase_timer.md
# cr_phase_timer

Phase timer and sensor conditioner for the country-road/highway intersection. It drives the country-road controller's `time_out` and `sensor` inputs. It tracks the same four-phase sequence as the controller, loads a per-phase duration, and pulses `time_out` when that phase has elapsed. It also synchronizes, debounces and latches the raw vehicle sensor, so the controller only ever sees clean, stable requests.

## Interface
Parameters:
- `CLK_DIV`, default 1000: clk cycles per timer tick (≥2).
- `T_HG`, default 30: highway-green / country-red minimum duration, in ticks (≥1).
- `T_HY`, default 3: highway-yellow duration, in ticks (≥1).
- `T_CG`, default 10: country-green duration, in ticks (≥1).
- `T_CY`, default 3: country-yellow duration, in ticks (≥1).
- `DB_LEN`, default 4: consecutive stable synchronized cycles needed to change the debounced sensor (≥1).
- `TW`, default 8: tick-counter width; must hold max(T_*)−1.

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `sensor_raw`, in, 1: asynchronous vehicle detector.
- `sensor_req`, out, 1: latched, debounced request; connects to the controller's `sensor`.
- `time_out`, out, 1: registered one-cycle phase-expiry pulse; connects to the controller's `time_out`.
- `phase`, out, 2: current phase. Encoding: 0=HG, 1=HY, 2=CG, 3=CY. Equals the controller state encoding.

## Operation
- Prescaler `pcnt` counts 0..CLK_DIV−1. `tick` is asserted when `pcnt==CLK_DIV−1`, after which `pcnt` wraps to 0.
  - `pcnt` is forced to 0 at every edge where `time_out` is asserted, so each phase starts on a tick boundary.
- Tick counter `tcnt` increments on `tick` and clears on phase entry. The phase is expired when `tick && tcnt==T_phase−1`.
- Phases HY, CG, CY: at expiry, assert `time_out` and advance `phase` (HY→CG→CY→HG) at the same edge.
- Phase HG:
  - At expiry, set internal `done`. `tcnt` and `pcnt` then hold.
  - On the first edge where `done && sensor_req`, assert `time_out`, set `phase`=HY and clear `done`.
  - If `sensor_req` is already high at expiry, the advance happens on the expiry edge itself.
  - With no request, HG lasts indefinitely and `time_out` is never asserted.
- Sensor path:
  - 2-FF synchronizer feeds a debounce counter.
  - The debounced value changes only after DB_LEN consecutive cycles of the opposite synchronized value.
  - Total latency from a `sensor_raw` edge to a debounced edge is DB_LEN+3 edges.
- `sensor_req`:
  - Set when the debounced value is 1 and `phase`==HG.
  - Cleared at the edge entering CG. Clear wins if set and clear coincide.
  - Held through HY regardless of `sensor_raw`.
  - Because the controller samples `sensor` and `time_out` together, `sensor_req` is guaranteed high when the controller leaves its idle state.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low): `phase`=0, `time_out`=0, `sensor_req`=0, `done`=0, `pcnt`=0, `tcnt`=0, synchronizer and debounce state 0.
- HG is entered at the first clk edge after reset release.
- Phases HY, CG and CY each last exactly T·CLK_DIV cycles from the entry edge to the `time_out` edge.
- HG lasts ≥ T_HG·CLK_DIV cycles.
- `time_out` is never high for two consecutive cycles. It is high exactly when `phase` has just changed.
- The controller's state lags `phase` by one edge.
- A reset asserted mid-phase discards all progress. On release, HG restarts with the full T_HG.

## Structure
- Shared package `traffic_pkg`:
  - Phase encodings PH_HG/PH_HY/PH_CG/PH_CY, shared with the controllers.
  - LED codes RED=3'b100, YEL=3'b010, GRN=3'b001.
- Sub-module `sensor_debounce` (synchronizer plus debounce counter, parameter DB_LEN), instantiated once.
- The phase FSM, prescaler, tick counter and request latch stay in the top module.

## Test plan
- Test parameters: CLK_DIV=4, T_HG=3, T_HY=2, T_CG=3, T_CY=1, DB_LEN=4. Cycle numbers count from reset release.
1. `sensor_raw` held 1 from reset → `time_out` pulses at cycles 12, 20, 32, 36 with `phase` 0→1→2→3→0. The pattern then repeats every 36 cycles.
2. `sensor_raw`=0 → `phase` stays 0 and `time_out` stays 0 for ≥1000 cycles. Raising `sensor_raw` at cycle 100 → `sensor_req` high at 107, `time_out` at 108, `phase`=1.
3. `sensor_raw` pulses 3 cycles wide, repeatedly, during HG → `sensor_req` stays 0 and no `time_out` is asserted.
4. `sensor_raw` high during HG, then dropped in HY → `sensor_req` stays 1 through HY and clears at CG entry. CG lasts exactly 12 cycles.
5. `rst_n` pulsed low in the middle of CG → outputs are 0 immediately. After release, the first `time_out` (with `sensor_raw` still high) arrives at cycle 12.
